// File: rtl/frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : frame_pkg
//  Purpose  : Shared types and constants for the single-wire frame link
//             (transmitter and receiver sides).
//  Revision : 1.0  initial release
// ============================================================================
package frame_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      SIZE  = 3'd2,
      DATA  = 3'd3,
      CRC   = 3'd4,
      STOP  = 3'd5
   } tx_state_t;

   localparam logic START_BIT  = 1'b1;
   localparam logic STOP_BIT   = 1'b0;
   localparam logic IDLE_LEVEL = 1'b0;
   localparam int   MAX_BYTES  = 15;
   localparam int   CRC_W      = 8;
   // Payload bus carries MAX_BYTES+1 bytes; the last one is never sent.
   localparam int   DATA_W     = (MAX_BYTES + 1) * 8;

   // Index of the final data byte. A size of 0 still sends one byte
   // because the receiver always consumes at least one.
   function automatic logic [3:0] last_byte_idx(input logic [3:0] size);
      return (size == 4'd0) ? 4'd0 : size - 4'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/crc8_serial.sv
`default_nettype none
// ============================================================================
//  Module   : crc8_serial
//  Purpose  : Bit-serial CRC-8 (MSB-first feed) with enable and synchronous
//             init. Shared by transmitter and receiver.
//  Revision : 1.0  initial release
// ============================================================================
module crc8_serial
   import frame_pkg::*;
#(
   parameter logic [CRC_W-1:0] CRC_POLY = 8'h07,
   parameter logic [CRC_W-1:0] CRC_INIT = 8'h00
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_init,
   input  logic             i_en,
   input  logic             i_bit,
   output logic [CRC_W-1:0] o_crc
);

   logic [CRC_W-1:0] r_crc;
   logic             w_fb;

   assign w_fb  = r_crc[CRC_W-1] ^ i_bit;
   assign o_crc = r_crc;

   // CRC register: init has priority over a bit update
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_crc <= CRC_INIT;
      end else if (i_init) begin
         r_crc <= CRC_INIT;
      end else if (i_en) begin
         r_crc <= {r_crc[CRC_W-2:0], 1'b0} ^ (w_fb ? CRC_POLY : '0);
      end
   end

endmodule
`default_nettype wire

// File: rtl/frame_transmit.sv
`default_nettype none
// ============================================================================
//  Module   : frame_transmit
//  Purpose  : Serial frame transmitter: start bit, 4-bit size, N data bytes
//             (MSB first), CRC-8, stop bit. Each bit lasts baudrate+1 clocks.
//  Options  : FRAME_TX_CRC_INJECT_EN - adds inject_crc_err input which
//             inverts the transmitted CRC bit 0 for the latched frame.
//  Revision : 1.0  initial release
// ============================================================================
module frame_transmit
   import frame_pkg::*;
#(
   parameter logic [CRC_W-1:0] CRC_POLY = 8'h07,
   parameter logic [CRC_W-1:0] CRC_INIT = 8'h00
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        baudrate,
   input  logic [3:0]        framesize,
   input  logic [DATA_W-1:0] framedata,
`ifdef FRAME_TX_CRC_INJECT_EN
   input  logic              inject_crc_err,
`endif
   output logic              TX,
   output logic              busy,
   output logic              done
);

   tx_state_t         r_state;
   tx_state_t         w_next_state;
   logic [7:0]        r_timer;
   logic [7:0]        r_baud;
   logic [3:0]        r_last;
   logic [3:0]        r_size_sh;
   logic [DATA_W-1:0] r_data;
   logic [2:0]        r_bitcnt;
   logic [3:0]        r_bytecnt;
   logic              r_done;
   logic              w_adv;
   logic              w_accept;
   logic              w_field_end;
   logic              w_tx;
   logic              w_inject;
   logic              w_crc_en;
   logic [CRC_W-1:0]  w_crc;

`ifdef FRAME_TX_CRC_INJECT_EN
   logic r_inject;

   // Injection request is captured with the frame so it cannot change mid-frame
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_inject <= 1'b0;
      end else if (w_accept) begin
         r_inject <= inject_crc_err;
      end
   end

   assign w_inject = r_inject;
`else
   assign w_inject = 1'b0;
`endif

   // A bit ends when its down-counter has reached zero
   assign w_adv    = (r_state != IDLE) && (r_timer == 8'd0);
   assign w_accept = (r_state == IDLE) && start;
   assign w_crc_en = w_adv && ((r_state == SIZE) || (r_state == DATA));

   // Last bit of the current field
   always_comb begin
      w_field_end = 1'b0;
      case (r_state)
         START:   w_field_end = 1'b1;
         SIZE:    w_field_end = (r_bitcnt == 3'd3);
         DATA:    w_field_end = (r_bitcnt == 3'd7) && (r_bytecnt == r_last);
         CRC:     w_field_end = (r_bitcnt == 3'd7);
         STOP:    w_field_end = 1'b1;
         default: w_field_end = 1'b0;
      endcase
   end

   // Line level decoded from registered state only; CRC bit 0 optionally inverted
   always_comb begin
      w_tx = IDLE_LEVEL;
      case (r_state)
         START:   w_tx = START_BIT;
         SIZE:    w_tx = r_size_sh[3];
         DATA:    w_tx = r_data[DATA_W-1];
         CRC:     w_tx = w_crc[3'd7 - r_bitcnt] ^ (w_inject && (r_bitcnt == 3'd7));
         STOP:    w_tx = STOP_BIT;
         default: w_tx = IDLE_LEVEL;
      endcase
   end

   // Next-state logic: transitions only at bit boundaries
   always_comb begin
      w_next_state = r_state;
      if (w_accept) begin
         w_next_state = START;
      end else if (w_adv && w_field_end) begin
         case (r_state)
            START:   w_next_state = SIZE;
            SIZE:    w_next_state = DATA;
            DATA:    w_next_state = CRC;
            CRC:     w_next_state = STOP;
            STOP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
         endcase
      end
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Datapath: frame latch, bit timer, field counters and shifters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_timer   <= 8'd0;
         r_baud    <= 8'd0;
         r_last    <= 4'd0;
         r_size_sh <= 4'd0;
         r_data    <= '0;
         r_bitcnt  <= 3'd0;
         r_bytecnt <= 4'd0;
         r_done    <= 1'b0;
      end else begin
         r_done <= (r_state == STOP) && w_adv;
         if (w_accept) begin
            r_timer   <= baudrate;
            r_baud    <= baudrate;
            r_last    <= last_byte_idx(framesize);
            r_size_sh <= framesize;
            r_data    <= framedata;
            r_bitcnt  <= 3'd0;
            r_bytecnt <= 4'd0;
         end else if (w_adv) begin
            r_timer  <= r_baud;
            // Within DATA the 3-bit counter wraps naturally at byte ends
            r_bitcnt <= w_field_end ? 3'd0 : r_bitcnt + 3'd1;
            if (r_state == SIZE) begin
               r_size_sh <= {r_size_sh[2:0], 1'b0};
            end
            if (r_state == DATA) begin
               r_data <= {r_data[DATA_W-2:0], 1'b0};
               if (r_bitcnt == 3'd7) begin
                  r_bytecnt <= r_bytecnt + 4'd1;
               end
            end
         end else if (r_state != IDLE) begin
            r_timer <= r_timer - 8'd1;
         end
      end
   end

   crc8_serial #(
      .CRC_POLY (CRC_POLY),
      .CRC_INIT (CRC_INIT)
   ) u_crc (
      .clk    (clk),
      .rst    (reset),
      .i_init (w_accept),
      .i_en   (w_crc_en),
      .i_bit  (w_tx),
      .o_crc  (w_crc)
   );

   assign TX   = w_tx;
   assign busy = (r_state != IDLE);
   assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_frame_transmit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frame_transmit
//  Purpose  : Self-checking bench for frame_transmit against a bit-list
//             reference model of the frame format.
//  Revision : 1.0  initial release
// ============================================================================
module tb_frame_transmit;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [7:0]   baudrate;
   logic [3:0]   framesize;
   logic [127:0] framedata;
   logic         TX;
   logic         busy;
   logic         done;
`ifdef FRAME_TX_CRC_INJECT_EN
   logic         inject_crc_err = 1'b0;
`endif

   int checks = 0;
   int errors = 0;
   bit exp_bits[$];

   always #5 clk = ~clk;

   frame_transmit dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .baudrate       (baudrate),
      .framesize      (framesize),
      .framedata      (framedata),
`ifdef FRAME_TX_CRC_INJECT_EN
      .inject_crc_err (inject_crc_err),
`endif
      .TX             (TX),
      .busy           (busy),
      .done           (done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] crc_step(input logic [7:0] c, input bit b);
      bit fb;
      fb = c[7] ^ b;
      return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
   endfunction

   // Reference frame as a list of line bits
   function automatic void build_bits(input logic [3:0] size, input logic [127:0] data, input bit inj);
      logic [7:0] crc;
      logic [7:0] by;
      int         n;
      bit         b;
      crc = 8'h00;
      exp_bits.delete();
      exp_bits.push_back(1'b1);
      for (int i = 3; i >= 0; i--) begin
         b = size[i];
         exp_bits.push_back(b);
         crc = crc_step(crc, b);
      end
      n = (size == 4'd0) ? 1 : int'(size);
      for (int k = 0; k < n; k++) begin
         by = data[(15-k)*8 +: 8];
         for (int i = 7; i >= 0; i--) begin
            b = by[i];
            exp_bits.push_back(b);
            crc = crc_step(crc, b);
         end
      end
      for (int i = 7; i >= 0; i--) exp_bits.push_back(crc[i] ^ ((i == 0) && inj));
      exp_bits.push_back(1'b0);
   endfunction

   // Called at #1 after the edge that accepted start; ends at the done cycle
   task automatic expect_frame(input int b, input bit scramble, input string tag);
      for (int i = 0; i < exp_bits.size(); i++) begin
         for (int c = 0; c <= b; c++) begin
            check({tag, "_line"}, {29'd0, TX, busy, done}, {29'd0, exp_bits[i], 1'b1, 1'b0});
            if (scramble && i == 0 && c == 0) begin
               framedata = {$urandom(), $urandom(), $urandom(), $urandom()};
               baudrate  = 8'($urandom_range(0, 3));
               framesize = 4'($urandom_range(0, 15));
            end
            @(posedge clk); #1;
         end
      end
      check({tag, "_done"}, {29'd0, TX, busy, done}, 32'b001);
   endtask

   task automatic start_frame(input logic [7:0] b, input logic [3:0] size,
                              input logic [127:0] data, input bit inj);
      @(negedge clk);
      baudrate  = b;
      framesize = size;
      framedata = data;
`ifdef FRAME_TX_CRC_INJECT_EN
      inject_crc_err = inj;
`endif
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (inj) framedata = ~framedata;
   endtask

   task automatic model_frame(input logic [7:0] b, input logic [3:0] size,
                              input logic [127:0] data, input bit inj, input string tag);
      build_bits(size, data, inj);
      start_frame(b, size, data, inj);
      expect_frame(int'(b), 1'b0, tag);
      @(posedge clk); #1;
      check({tag, "_idle"}, {29'd0, TX, busy, done}, 32'b000);
   endtask

   initial begin
      logic [21:0]  fixed;
      logic [127:0] d;
      logic [7:0]   b1;
      logic [3:0]   s1;
      logic [127:0] d1;

      reset = 1'b1; start = 1'b0; baudrate = '0; framesize = '0; framedata = '0;
      repeat (3) @(posedge clk);
      #1 check("reset_state", {29'd0, TX, busy, done}, 32'b000);
      @(negedge clk) reset = 1'b0;
      @(posedge clk); #1;
      check("idle_after_reset", {29'd0, TX, busy, done}, 32'b000);

      // Fixed 0xA5 frame against hand-derived bit string (CRC 0x67)
      fixed = 22'b1_0001_10100101_01100111_0;
      exp_bits.delete();
      for (int i = 21; i >= 0; i--) exp_bits.push_back(fixed[i]);
      d = {8'hA5, 120'h0};
      d[119:0] = {$urandom(), $urandom(), $urandom(), 24'($urandom())};
      start_frame(8'd3, 4'd1, d, 1'b0);
      expect_frame(3, 1'b0, "fixed_a5");
      @(posedge clk); #1;
      check("fixed_a5_idle", {29'd0, TX, busy, done}, 32'b000);

      // Size 0 still sends one byte; baudrate 0
      d = {8'hA5, 120'h0};
      model_frame(8'd0, 4'd0, d, 1'b0, "size0");

      // Maximum size, last bus byte must never appear
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      model_frame(8'd1, 4'd15, d, 1'b0, "size15");

      // Random frames
      for (int n = 0; n < 6; n++) begin
         d = {$urandom(), $urandom(), $urandom(), $urandom()};
         model_frame(8'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), d, 1'b0, "rand");
      end

      // start held high with inputs changed mid-frame, then back-to-back frame
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      build_bits(4'd2, d, 1'b0);
      @(negedge clk);
      baudrate = 8'd2; framesize = 4'd2; framedata = d; start = 1'b1;
      @(posedge clk); #1;
      expect_frame(2, 1'b1, "hold1");
      b1 = baudrate; s1 = framesize; d1 = framedata;
      build_bits(s1, d1, 1'b0);
      @(posedge clk); #1;
      start = 1'b0;
      expect_frame(int'(b1), 1'b0, "hold2");
      @(posedge clk); #1;
      check("hold2_idle", {29'd0, TX, busy, done}, 32'b000);

      // Asynchronous reset during DATA
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      start_frame(8'd1, 4'd3, d, 1'b0);
      repeat (14) @(posedge clk);
      #1 check("pre_reset_busy", {31'd0, busy}, 32'd1);
      #2 reset = 1'b1;
      #1 check("async_reset", {29'd0, TX, busy, done}, 32'b000);
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         check("post_reset_quiet", {29'd0, TX, busy, done}, 32'b000);
      end
      model_frame(8'd1, 4'd2, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, "after_reset");

`ifdef FRAME_TX_CRC_INJECT_EN
      fixed = 22'b1_0001_10100101_01100110_0;
      exp_bits.delete();
      for (int i = 21; i >= 0; i--) exp_bits.push_back(fixed[i]);
      start_frame(8'd3, 4'd1, {8'hA5, 120'h0}, 1'b1);
      expect_frame(3, 1'b0, "inject");
      inject_crc_err = 1'b0;
      model_frame(8'd0, 4'd1, {8'hA5, 120'h0}, 1'b0, "inject_off");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/frame_transmit.md
Name: frame_transmit

Overview:
- Serial frame transmitter; the upstream partner of the frame receiver on the same single-wire link.
- Serialises one frame per request: start bit, 4-bit frame size, N data bytes, CRC-8, stop bit.
- Every bit is held for baudrate+1 clocks, matching the receiver's per-bit sampling window.
- Idle line is 0, start bit is 1, stop bit is 0.

Parameters:
- CRC_POLY, 8'h07, CRC-8 polynomial (x^8+x^2+x+1).
- CRC_INIT, 8'h00, CRC register value at frame start.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  frame request; sampled only in IDLE.
- baudrate  input  8  bit period minus one, in clocks.
- framesize  input  4  number of data bytes in the frame.
- framedata  input  128  payload; byte k = framedata[(15-k)*8+7 -: 8].
- TX  output  1  serial line.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the stop bit period ends.

Behaviour:
- Reset values: TX=0, busy=0, done=0, state=IDLE, all counters and the CRC register cleared to CRC_INIT.
- IDLE, when start=1:
  - latch baudrate, framesize and framedata;
  - set CRC to CRC_INIT;
  - enter START next cycle with TX=1 and busy=1.
- start is ignored while busy. Input changes after latching have no effect on the frame in progress.
- Bit timer: 8-bit down-counter loaded with the latched baudrate at each bit boundary. The bit ends when the counter is 0 and a bit-advance occurs, so each bit is exactly baudrate+1 clocks. baudrate=0 gives 1 clock per bit.
- States and transitions (each transition happens on a bit-advance):
  - START: TX=1 for one bit. Next: SIZE.
  - SIZE: sends framesize[3] down to framesize[0], MSB first; each bit is fed to the CRC. Next: DATA.
  - DATA: sends bytes k = 0..N-1, MSB first; each bit is fed to the CRC. N = framesize, except framesize=0 sends 1 byte (the header still carries 0), because the receiver always consumes at least one byte. Byte 15 (framedata[7:0]) is never sent. Next: CRC.
  - CRC: sends the CRC register bits [7] down to [0]. The register is frozen (no update) during this state. Next: STOP.
  - STOP: TX=0 for one bit. At the end of the bit: done=1 for one cycle, busy=0, return to IDLE.
- The next frame may start in the cycle after done; back-to-back frames are legal.
- CRC update, once per bit fed at that bit's advance:
  - fb = crc[7] ^ bit;
  - crc = {crc[6:0],1'b0} ^ (fb ? CRC_POLY : 0).
- Frame length = (14 + 8N) × (baudrate+1) clocks, measured from the first TX=1 cycle to the done cycle (exclusive).
- Reset asserted mid-frame: TX drops to 0 immediately (asynchronous), state=IDLE, and no done pulse is produced.

Optional Feature:
- Macro: FRAME_TX_CRC_INJECT_EN.
- When defined:
  - adds input inject_crc_err (1 bit), latched together with start;
  - if the latched value is 1, the transmitted CRC bit 0 is inverted, forcing a CRC error at the receiver;
  - the internal CRC register itself is unaffected.
- When undefined: no extra port, and the CRC is always sent unmodified.

Decomposition:
- Shared package frame_pkg:
  - tx_state_t enum {IDLE, START, SIZE, DATA, CRC, STOP};
  - constants START_BIT=1, STOP_BIT=0, IDLE_LEVEL=0, MAX_BYTES=15, CRC_W=8.
- One sub-module, crc8_serial: bit-serial CRC with enable, synchronous init, bit in, 8-bit out, parameterised by CRC_POLY. The receiver side can reuse it.

Test Plan:
- Fixed-value frame: baudrate=3, framesize=1, byte0=8'hA5, start pulse → TX bit sequence 1, 0001, 10100101, CRC 01100111 (0x67), 0; each bit held 4 clocks; done exactly 88 clocks after the first TX=1 cycle; busy low afterwards.
- framesize=0, baudrate=0, byte0=8'hA5 → header 0000 followed by one data byte 10100101; frame length 22 clocks; CRC matches a bit-accurate model.
- framesize=15, baudrate=1, random framedata → 15 bytes sent, framedata[7:0] never sent, frame length 268 clocks; loopback into the receiver gives crce=0, fe=0, and matching framedata bytes 0..14.
- start held high throughout a frame, and inputs changed mid-frame → exactly one frame with the originally latched contents; a second frame begins the cycle after done.
- reset asserted in the middle of DATA → TX=0 and busy=0 in the same cycle, no done pulse; a new start afterwards produces a clean frame.
- With FRAME_TX_CRC_INJECT_EN defined and inject_crc_err=1 on the 8'hA5 frame → CRC sent as 01100110; loopback receiver sets crce=1.
